// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for the single-cycle core.
// It holds the current fetch address. Each cycle the PC does one of these:
// advance by STEP, take a branch/jump redirect, return through an optional
// return-address stack (RAS), stall, or halt.
//
// Optional feature macro: PC_SEQ_RAS_EN. When it is defined, a RAS of
// RAS_DEPTH entries is built. When it is undefined, call and ret are
// ignored, ras_empty is tied to 1 and the RAS flags are tied to 0.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   stall             hold the PC this cycle
//   halt              enter HALTED (only from RUN, and only when not stalled)
//   branch_valid      redirect to branch_target (also resumes from HALTED)
//   branch_target     redirect address, used unmasked
//   call              qualifies a branch as a call (pushes cur_pc+STEP)
//   ret               return to the RAS top
//   cur_pc            registered current PC
//   next_pc           combinational value cur_pc takes at the next edge
//   halted            registered, high in HALTED
//   ras_empty         registered, RAS holds no entries
//   ras_overflow      registered pulse: a push discarded the oldest entry
//   ras_underflow     registered pulse: ret with an empty RAS
module pc_sequencer #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               STEP         = 4,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             halt,
  input  logic             branch_valid,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] cur_pc,
  output logic [WIDTH-1:0] next_pc,
  output logic             halted,
  output logic             ras_empty,
  output logic             ras_overflow,
  output logic             ras_underflow
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  typedef enum logic [0:0] {RUN = 1'b0, HALTED = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_inc;
  logic             push, pop;
  logic             ovf_d, unf_d;

`ifdef PC_SEQ_RAS_EN
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);

  // The stack is a circular buffer. wr_ptr points at the next free slot.
  // When the stack is full, that slot holds the oldest entry, so a push
  // overwrites the oldest entry without any extra logic.
  logic [RAS_DEPTH-1:0][WIDTH-1:0] ras_q, ras_d;
  logic [PW-1:0]                   wr_ptr_q, wr_ptr_d, top_idx, ptr_inc;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic                            empty_q, empty_d;
  logic                            ovf_q, unf_q;
  logic [WIDTH-1:0]                ras_top;

  assign top_idx = (wr_ptr_q == '0) ? PW'(RAS_DEPTH - 1) : wr_ptr_q - 1'b1;
  assign ptr_inc = (wr_ptr_q == PW'(RAS_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
  assign ras_top = ras_q[top_idx];
`endif

  assign pc_inc = pc_q + STEP_W;

  always_comb begin
    pc_d    = pc_inc;
    state_d = state_q;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    case (state_q)
      RUN: begin
        if (stall) begin
          pc_d = pc_q;
        end else begin
          if (halt) state_d = HALTED;
`ifdef PC_SEQ_RAS_EN
          push = branch_valid & call;
          if (ret && !empty_q) begin
            pc_d = ras_top;
            pop  = 1'b1;
          end else begin
            unf_d = ret;
            if (branch_valid) pc_d = branch_target;
          end
`else
          if (branch_valid) pc_d = branch_target;
`endif
        end
      end
      HALTED: begin
        // Only a redirect leaves HALTED. All other requests are ignored.
        if (branch_valid) begin
          pc_d    = branch_target;
          state_d = RUN;
        end else begin
          pc_d = pc_q;
        end
      end
      default: begin
        pc_d    = RESET_VECTOR;
        state_d = RUN;
      end
    endcase
  end

`ifdef PC_SEQ_RAS_EN
  always_comb begin
    ras_d    = ras_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (push && pop) begin
      // Tail call: the pushed return address replaces the popped slot.
      ras_d[top_idx] = pc_inc;
    end else if (push) begin
      ras_d[wr_ptr_q] = pc_inc;
      wr_ptr_d        = ptr_inc;
      if (cnt_q != CW'(RAS_DEPTH)) cnt_d = cnt_q + 1'b1;
    end else if (pop) begin
      wr_ptr_d = top_idx;
      cnt_d    = cnt_q - 1'b1;
    end
    empty_d = (cnt_d == '0);
  end

  // Stack data needs no reset. The pointer and count make stale entries
  // unreachable.
  always_ff @(posedge clk) ras_q <= ras_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      empty_q  <= empty_d;
      ovf_q    <= push & ~pop & (cnt_q == CW'(RAS_DEPTH));
      unf_q    <= unf_d;
    end
  end

  assign ras_empty     = empty_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;
`else
  logic unused_ras;
  assign unused_ras    = ^{call, ret, push, pop, ovf_d, unf_d};
  assign ras_empty     = 1'b1;
  assign ras_overflow  = 1'b0;
  assign ras_underflow = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign cur_pc  = pc_q;
  assign next_pc = reset ? RESET_VECTOR : pc_d;
  assign halted  = (state_q == HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

`ifdef PC_SEQ_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, stall, halt, branch_valid, call, ret;
  logic [31:0] branch_target;
  logic [31:0] cur_pc, next_pc;
  logic        halted, ras_empty, ras_overflow, ras_underflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic        h, e, o, u;
  } exp_t;
  exp_t sb[$];

  pc_sequencer #(
    .WIDTH(32), .RESET_VECTOR(32'h100), .STEP(4), .RAS_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .halt(halt),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .call(call), .ret(ret), .cur_pc(cur_pc), .next_pc(next_pc),
    .halted(halted), .ras_empty(ras_empty), .ras_overflow(ras_overflow),
    .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs and push the expected post-edge state.
  // next_pc is compared before the edge. The registered outputs are
  // compared 1ns after the edge, against the popped expectation.
  // The e/o/u arguments are the RAS-build values. Without the RAS the
  // empty flag is always 1 and the pulse flags are always 0.
  task automatic step(input logic rst, st, hl, bv, input logic [31:0] tgt,
                      input logic cl, rt, input logic [31:0] epc,
                      input logic eh, ee, eo, eu);
    exp_t x;
    reset = rst; stall = st; halt = hl; branch_valid = bv;
    branch_target = tgt; call = cl; ret = rt;
    x.pc = epc; x.h = eh; x.e = RAS ? ee : 1'b1; x.o = RAS & eo; x.u = RAS & eu;
    sb.push_back(x);
    #1;
    chk("next_pc", next_pc, epc);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      chk("cur_pc", cur_pc, x.pc);
      chk("halted", {31'd0, halted}, {31'd0, x.h});
      chk("ras_empty", {31'd0, ras_empty}, {31'd0, x.e});
      chk("ras_overflow", {31'd0, ras_overflow}, {31'd0, x.o});
      chk("ras_underflow", {31'd0, ras_underflow}, {31'd0, x.u});
    end
  endtask

  initial begin
    //   rst st hl bv target        cl rt  exp_pc                   h e o u
    // reset held for two cycles, then free increments
    step(1, 0, 0, 0, 32'h0,        0, 0, 32'h100,                  0, 1, 0, 0);
    step(1, 0, 0, 0, 32'h0,        0, 0, 32'h100,                  0, 1, 0, 0);
    step(0, 0, 0, 0, 32'h0,        0, 0, 32'h104,                  0, 1, 0, 0);
    step(0, 0, 0, 0, 32'h0,        0, 0, 32'h108,                  0, 1, 0, 0);
    step(0, 0, 0, 0, 32'h0,        0, 0, 32'h10C,                  0, 1, 0, 0);
    // stall beats branch
    step(0, 1, 0, 1, 32'h200,      0, 0, 32'h10C,                  0, 1, 0, 0);
    step(0, 0, 0, 1, 32'h200,      0, 0, 32'h200,                  0, 1, 0, 0);
    // five calls, overflow on the fifth (0x4 discarded)
    step(0, 0, 0, 1, 32'h0,        0, 0, 32'h0,                    0, 1, 0, 0);
    step(0, 0, 0, 1, 32'h10,       1, 0, 32'h10,                   0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h20,       1, 0, 32'h20,                   0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h30,       1, 0, 32'h30,                   0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h40,       1, 0, 32'h40,                   0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h50,       1, 0, 32'h50,                   0, 0, 1, 0);
    // four returns, then underflow
    step(0, 0, 0, 0, 32'h0,        0, 1, RAS ? 32'h44 : 32'h54,    0, 0, 0, 0);
    step(0, 0, 0, 0, 32'h0,        0, 1, RAS ? 32'h34 : 32'h58,    0, 0, 0, 0);
    step(0, 0, 0, 0, 32'h0,        0, 1, RAS ? 32'h24 : 32'h5C,    0, 0, 0, 0);
    step(0, 0, 0, 0, 32'h0,        0, 1, RAS ? 32'h14 : 32'h60,    0, 1, 0, 0);
    step(0, 0, 0, 0, 32'h0,        0, 1, RAS ? 32'h18 : 32'h64,    0, 1, 0, 1);
    // build stack {0x1C, 0x54}, then tail call from 0x80
    step(0, 0, 0, 1, 32'h50,       1, 0, 32'h50,                   0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h80,       1, 0, 32'h80,                   0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h200,      1, 1, RAS ? 32'h54 : 32'h200,   0, 0, 0, 0);
    step(0, 0, 0, 0, 32'h0,        0, 1, RAS ? 32'h84 : 32'h204,   0, 0, 0, 0);
    step(0, 0, 0, 0, 32'h0,        0, 1, RAS ? 32'h1C : 32'h208,   0, 1, 0, 0);
    step(0, 0, 0, 0, 32'h0,        0, 1, RAS ? 32'h20 : 32'h20C,   0, 1, 0, 1);
    // halt at 0x300, hold through ignored requests, resume at the wrap point
    step(0, 0, 0, 1, 32'h300,      0, 0, 32'h300,                  0, 1, 0, 0);
    step(0, 0, 1, 0, 32'h0,        0, 0, 32'h304,                  1, 1, 0, 0);
    step(0, 1, 0, 0, 32'h0,        0, 1, 32'h304,                  1, 1, 0, 0);
    step(0, 0, 0, 0, 32'h0,        0, 1, 32'h304,                  1, 1, 0, 0);
    step(0, 0, 1, 0, 32'h0,        0, 0, 32'h304,                  1, 1, 0, 0);
    step(0, 0, 0, 0, 32'h0,        1, 1, 32'h304,                  1, 1, 0, 0);
    step(0, 1, 1, 0, 32'h0,        0, 0, 32'h304,                  1, 1, 0, 0);
    step(0, 0, 0, 1, 32'hFFFFFFFC, 0, 0, 32'hFFFFFFFC,             0, 1, 0, 0);
    step(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,                    0, 1, 0, 0);
    // three entries, then halt, then reset mid-operation
    step(0, 0, 0, 1, 32'h40,       1, 0, 32'h40,                   0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h80,       1, 0, 32'h80,                   0, 0, 0, 0);
    step(0, 0, 0, 1, 32'hC0,       1, 0, 32'hC0,                   0, 0, 0, 0);
    step(0, 0, 1, 0, 32'h0,        0, 0, 32'hC4,                   1, 0, 0, 0);
    step(0, 0, 0, 0, 32'h0,        0, 0, 32'hC4,                   1, 0, 0, 0);
    step(1, 1, 1, 0, 32'h0,        0, 1, 32'h100,                  0, 1, 0, 0);
    step(0, 0, 0, 0, 32'h0,        0, 1, 32'h104,                  0, 1, 0, 1);
    // a stalled call+ret neither moves the PC nor raises any flag
    step(0, 1, 0, 1, 32'h500,      1, 1, 32'h104,                  0, 1, 0, 0);
    step(0, 0, 0, 0, 32'h0,        0, 0, 32'h108,                  0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
